fir_filter_mc: RTL
==================

Name: fir_filter_mc

Overview:
Parametrised multi-channel FIR filter in plain RTL, with no vendor IP core. It replaces the single-channel IP-core wrapper used on the ADC data path. A single time-multiplexed MAC serves NUM_CHAN channels, each with its own circular sample history. Coefficients are runtime-loadable and shared by all channels. Output is rounded, shifted and saturated, with a bypass mode and a sticky overrun flag.

Parameters:
DATA_W, 16, signed sample and output width
COEF_W, 16, signed coefficient width (Q1.(COEF_W-1) when SHIFT=COEF_W-1)
TAPS, 16, filter length, >=2
NUM_CHAN, 4, number of independent channels, >=1
ACC_W, 40, accumulator width, >= DATA_W+COEF_W+clog2(TAPS)
SHIFT, 15, right shift applied to the accumulator, >=1

Ports:
sysclk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  sample strobe
in_chan  in  CW=max(1,clog2(NUM_CHAN))  channel index of sample
in_data  in  DATA_W  signed sample
in_ready  out  1  high when a sample can be accepted
bypass  in  1  sampled at accept; 1 = pass the sample through unfiltered
coef_wr  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  tap index
coef_data  in  COEF_W  signed coefficient
out_valid  out  1  one-cycle result strobe
out_chan  out  CW  channel of the result
out_data  out  DATA_W  signed filtered sample
overrun  out  1  sticky: a sample was dropped
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (async):
  - state=IDLE; all histories, coefficients and write pointers = 0.
  - out_valid=0, out_chan=0, out_data=0, overrun=0; in_ready=1 after release.
  - Reset asserted mid-operation aborts the computation: no out_valid for that sample.
- States: IDLE, MAC, DONE. in_ready = (state==IDLE).
- IDLE:
  - Accept when in_valid && in_chan<NUM_CHAN (edge E0).
  - Write in_data to hist[in_chan][wp[in_chan]]; latch chan, bypass and sample; acc=0, k=0.
  - Next state: MAC, or DONE if bypass.
  - in_chan>=NUM_CHAN: sample ignored; no state change, no output, no overrun.
- MAC, edges E1..E_TAPS:
  - Each edge does acc += sext(hist[ch][(wp[ch]-k) mod TAPS] * coef[k]); k++.
  - k=0 is the newest sample; after TAPS edges go to DONE.
- DONE (one edge):
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round half up).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Bypass: out_data = latched sample.
  - out_chan=ch, out_valid=1 for exactly one cycle; wp[ch] = (wp[ch]+1) mod TAPS; next state IDLE.
- Latency: out_valid high in the cycle after edge E_TAPS+1 (bypass: after E1). Throughput: one sample per TAPS+2 cycles.
- out_data and out_chan hold their values until the next result.
- Overrun:
  - in_valid while in_ready=0 drops the sample and sets overrun=1.
  - clr_overrun clears it; a simultaneous set wins.
- Coefficients:
  - coef_wr writes coef[coef_addr] only when state==IDLE; writes are ignored otherwise.
  - A write on the same edge as an accept takes effect for that sample.
- Product and accumulation are signed, full precision, sign-extended to ACC_W; the accumulator never wraps within legal parameters.
- Write pointer wraps TAPS-1 -> 0. Each channel's history is untouched by the other channels.

Test Plan:
1. Impulse:
   - Setup: TAPS=16; coef[0..3]=0x4000,0x2000,0x1000,0x0800, others 0.
   - Stimulus: ch0 sample 1000, then 15 zeros.
   - Required: outputs 500, 250, 125, 63, then 0; out_valid exactly TAPS+2 cycles after each accept.
2. Channel isolation:
   - Stimulus: ch0 impulse from test 1, interleaved with ch1 constant 100.
   - Required: ch0 sequence unchanged. ch1 ramps 50, 75, 88, 94, then holds 94 (sum 0.9375). out_chan matches each result.
3. Saturation:
   - Setup: all coefs 0x7FFF.
   - Stimulus: 16 samples 32767 on ch2, then 16 samples -32768.
   - Required: output clamps at 32767, then -32768; no wrap to the opposite sign.
4. Overrun:
   - Stimulus: in_valid held high for 40 cycles.
   - Required: only samples seen while in_ready=1 are accepted (one per 18 cycles). overrun=1 after the first drop; clr_overrun pulse returns it to 0.
   - Also: clr_overrun on the same cycle as a drop -> overrun stays 1.
5. Bypass and coef-write lockout:
   - Bypass: bypass=1, ch3 sample 0x1234 -> out_data=0x1234 with out_valid 2 cycles after accept.
   - Lockout: coef_wr during MAC is ignored; the next result still uses the old coefficients.
6. Reset mid-MAC:
   - Stimulus: reset at E5 of a MAC.
   - Required: out_valid stays 0; histories and coefficients are cleared. After release, in_ready=1 and a new impulse yields all-zero output (coefficients are 0).

Source files
------------

// File: rtl/fir_filter_mc_if.sv
// rtl/fir_filter_mc_if.sv - sample, coefficient and result bus of the multi-channel FIR
interface fir_filter_mc_if #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 16,
    parameter int NUM_CHAN = 4
);
    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int AW = $clog2(TAPS);

    logic                     in_valid;
    logic [CW-1:0]            in_chan;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     bypass;
    logic                     coef_wr;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_valid;
    logic [CW-1:0]            out_chan;
    logic signed [DATA_W-1:0] out_data;
    logic                     overrun;
    logic                     clr_overrun;

    modport master (
        output in_valid, in_chan, in_data, bypass, coef_wr, coef_addr, coef_data, clr_overrun,
        input  in_ready, out_valid, out_chan, out_data, overrun
    );

    modport slave (
        input  in_valid, in_chan, in_data, bypass, coef_wr, coef_addr, coef_data, clr_overrun,
        output in_ready, out_valid, out_chan, out_data, overrun
    );
endinterface

// File: rtl/fir_filter_mc.sv
// rtl/fir_filter_mc.sv - multi-channel FIR, one shared MAC, per-channel circular histories
module fir_filter_mc #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 16,
    parameter int NUM_CHAN = 4,
    parameter int ACC_W    = 40,
    parameter int SHIFT    = 15
) (
    input  logic           sysclk,
    input  logic           reset,
    fir_filter_mc_if.slave bus
);
    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int AW = $clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;

    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W   = (AW+1)'(TAPS);
    localparam logic [CW:0]   NCH_W    = (CW+1)'(NUM_CHAN);
    localparam logic signed [ACC_W-1:0] RND_C = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] hist_q [NUM_CHAN][TAPS];
    logic signed [DATA_W-1:0] hist_d [NUM_CHAN][TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic [AW-1:0]            wp_q [NUM_CHAN];
    logic [AW-1:0]            wp_d [NUM_CHAN];
    logic [CW-1:0]            ch_q, ch_d;
    logic                     byp_q, byp_d;
    logic signed [DATA_W-1:0] samp_q, samp_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AW-1:0]            k_q, k_d;
    logic                     out_valid_q, out_valid_d;
    logic [CW-1:0]            out_chan_q, out_chan_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     overrun_q, overrun_d;

    logic [AW:0]              rd_sum, rd_wrap;
    logic [AW-1:0]            rd_idx;
    logic signed [PW-1:0]     tap_x, coef_x, prod;
    logic signed [ACC_W-1:0]  prod_ext, rnd, shifted;
    logic signed [DATA_W-1:0] sat;
    logic                     chan_ok, addr_ok, accept;

    // Tap k reads the sample k positions older than the newest one at wp.
    assign rd_sum   = {1'b0, wp_q[ch_q]} + TAPS_W - {1'b0, k_q};
    assign rd_wrap  = rd_sum - TAPS_W;
    assign rd_idx   = (rd_sum >= TAPS_W) ? rd_wrap[AW-1:0] : rd_sum[AW-1:0];
    assign tap_x    = PW'(hist_q[ch_q][rd_idx]);
    assign coef_x   = PW'(coef_q[k_q]);
    assign prod     = tap_x * coef_x;
    assign prod_ext = ACC_W'(prod);

    assign rnd      = acc_q + RND_C;
    assign shifted  = rnd >>> SHIFT;
    assign sat      = (shifted > MAX_V) ? MAX_V[DATA_W-1:0] :
                      (shifted < MIN_V) ? MIN_V[DATA_W-1:0] : shifted[DATA_W-1:0];

    assign chan_ok  = {1'b0, bus.in_chan} < NCH_W;
    assign addr_ok  = {1'b0, bus.coef_addr} < TAPS_W;
    assign accept   = bus.in_valid && (state_q == IDLE) && chan_ok;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        coef_d      = coef_q;
        wp_d        = wp_q;
        ch_d        = ch_q;
        byp_d       = byp_q;
        samp_d      = samp_q;
        acc_d       = acc_q;
        k_d         = k_q;
        out_valid_d = 1'b0;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.coef_wr && addr_ok) begin
                    coef_d[bus.coef_addr] = bus.coef_data;
                end
                if (accept) begin
                    hist_d[bus.in_chan][wp_q[bus.in_chan]] = bus.in_data;
                    ch_d    = bus.in_chan;
                    byp_d   = bus.bypass;
                    samp_d  = bus.in_data;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = bus.bypass ? DONE : MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                k_d   = k_q + 1'b1;
                if (k_q == LAST_TAP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                out_chan_d  = ch_q;
                out_data_d  = byp_q ? samp_q : sat;
                wp_d[ch_q]  = (wp_q[ch_q] == LAST_TAP) ? '0 : wp_q[ch_q] + 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A drop on the same cycle as a clear keeps the flag set.
        if (bus.in_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hist_q      <= '{default: '0};
            coef_q      <= '{default: '0};
            wp_q        <= '{default: '0};
            ch_q        <= '0;
            byp_q       <= 1'b0;
            samp_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            coef_q      <= coef_d;
            wp_q        <= wp_d;
            ch_q        <= ch_d;
            byp_q       <= byp_d;
            samp_q      <= samp_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_data  = out_data_q;
    assign bus.overrun   = overrun_q;
endmodule
